// File: rtl/rx_arb_pkg.sv
// rtl/rx_arb_pkg.sv - shared types and round-robin pick function for the RX stream arbiter
package rx_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam int DEF_NUM_SRC = 2;
    localparam int GRANT_W     = $clog2(DEF_NUM_SRC);
    localparam int MAX_SRC     = 32;

    // First requester strictly after 'last', wrapping modulo n; returns 'last' when nobody asks.
    function automatic int rr_pick(input logic [MAX_SRC-1:0] req,
                                   input int                 last,
                                   input int                 n = DEF_NUM_SRC);
        int   idx;
        logic found;
        rr_pick = last;
        found   = 1'b0;
        for (int k = 1; k <= MAX_SRC; k++) begin
            idx = (last + k) % n;
            if (!found && (k <= n) && req[idx[4:0]]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin grant selection from a request vector
module rr_arbiter
    import rx_arb_pkg::*;
#(
    parameter int N  = 2,
    parameter int GW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [GW-1:0] last_i,
    output logic [GW-1:0] grant_o,
    output logic          any_req_o
);

    logic [MAX_SRC-1:0] req_ext;

    assign req_ext   = MAX_SRC'(req_i);
    assign grant_o   = GW'(rr_pick(req_ext, int'(last_i), N));
    assign any_req_o = |req_i;

endmodule

// File: rtl/rx_stream_arbiter.sv
// rtl/rx_stream_arbiter.sv - frame-granular round-robin mux of NUM_SRC streams onto one RX FIFO port
module rx_stream_arbiter
    import rx_arb_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int NUM_SRC   = 2,
    parameter int MAX_BEATS = 512,
    parameter int CNT_W     = 16
) (
    input  logic                        clk_83,
    input  logic                        reset_n,
    input  logic [NUM_SRC*DATA_W-1:0]   s_tdata,
    input  logic [NUM_SRC-1:0]          s_tvalid,
    input  logic [NUM_SRC-1:0]          s_tlast,
    output logic [NUM_SRC-1:0]          s_tready,
    output logic [DATA_W-1:0]           m_tdata,
    output logic                        m_tvalid,
    output logic                        m_tlast,
    input  logic                        m_tready,
    output logic [$clog2(NUM_SRC)-1:0]  grant_id,
    output logic                        busy,
    output logic [NUM_SRC*CNT_W-1:0]    frame_cnt,
    output logic [NUM_SRC*CNT_W-1:0]    trunc_cnt
);

    localparam int GW = $clog2(NUM_SRC);
    localparam int BW = $clog2(MAX_BEATS);

    state_e                         state_q, state_d;
    logic [GW-1:0]                  grant_q, grant_d;
    logic [BW-1:0]                  beat_q, beat_d;
    logic [NUM_SRC-1:0][CNT_W-1:0]  frame_q, frame_d;
    logic [NUM_SRC-1:0][CNT_W-1:0]  trunc_q, trunc_d;

    logic [GW-1:0]      pick;
    logic               any_req;
    logic [DATA_W-1:0]  src_data;
    logic               src_valid;
    logic               src_last;
    logic               at_limit;

    rr_arbiter #(
        .N  (NUM_SRC),
        .GW (GW)
    ) u_rr (
        .req_i     (s_tvalid),
        .last_i    (grant_q),
        .grant_o   (pick),
        .any_req_o (any_req)
    );

    assign src_data  = s_tdata[int'(grant_q)*DATA_W +: DATA_W];
    assign src_valid = s_tvalid[grant_q];
    assign src_last  = s_tlast[grant_q];
    assign at_limit  = (beat_q == BW'(MAX_BEATS - 1));

    always_ff @(posedge clk_83) begin
        if (!reset_n) begin
            state_q <= IDLE;
            grant_q <= GW'(NUM_SRC - 1);
            beat_q  <= '0;
            frame_q <= '0;
            trunc_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            beat_q  <= beat_d;
            frame_q <= frame_d;
            trunc_q <= trunc_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        beat_d   = beat_q;
        frame_d  = frame_q;
        trunc_d  = trunc_q;
        s_tready = '0;
        m_tdata  = '0;
        m_tvalid = 1'b0;
        m_tlast  = 1'b0;

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_d = pick;
                    state_d = PASS;
                end
            end

            PASS: begin
                m_tdata            = src_data;
                m_tvalid           = src_valid;
                m_tlast            = src_last | at_limit;
                s_tready[grant_q]  = m_tready;
                if (src_valid && m_tready) begin
                    if (src_last || at_limit) begin
                        frame_d[grant_q] = frame_q[grant_q] + CNT_W'(1);
                        beat_d           = '0;
                        if (src_last) begin
                            state_d = IDLE;
                        end else begin
                            // Limit hit mid-frame: the forced tlast closes it downstream, rest is dropped.
                            trunc_d[grant_q] = trunc_q[grant_q] + CNT_W'(1);
                            state_d          = DRAIN;
                        end
                    end else begin
                        beat_d = beat_q + BW'(1);
                    end
                end
            end

            DRAIN: begin
                s_tready[grant_q] = 1'b1;
                if (src_valid && src_last) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign grant_id  = grant_q;
    assign busy      = (state_q != IDLE);
    assign frame_cnt = frame_q;
    assign trunc_cnt = trunc_q;

endmodule

// File: tb/tb_rx_stream_arbiter.sv
// tb/tb_rx_stream_arbiter.sv - directed self-checking bench for rx_stream_arbiter
module tb_rx_stream_arbiter;

    localparam int DW  = 32;
    localparam int NS  = 2;
    localparam int MB  = 8;
    localparam int CW  = 16;

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
        logic          t;
    } beat_t;

    logic                clk;
    logic                reset_n;
    logic [NS*DW-1:0]    s_tdata;
    logic [NS-1:0]       s_tvalid;
    logic [NS-1:0]       s_tlast;
    logic [NS-1:0]       s_tready;
    logic [DW-1:0]       m_tdata;
    logic                m_tvalid;
    logic                m_tlast;
    logic                m_tready;
    logic [0:0]          grant_id;
    logic                busy;
    logic [NS*CW-1:0]    frame_cnt;
    logic [NS*CW-1:0]    trunc_cnt;

    rx_stream_arbiter #(
        .DATA_W    (DW),
        .NUM_SRC   (NS),
        .MAX_BEATS (MB),
        .CNT_W     (CW)
    ) dut (
        .clk_83    (clk),
        .reset_n   (reset_n),
        .s_tdata   (s_tdata),
        .s_tvalid  (s_tvalid),
        .s_tlast   (s_tlast),
        .s_tready  (s_tready),
        .m_tdata   (m_tdata),
        .m_tvalid  (m_tvalid),
        .m_tlast   (m_tlast),
        .m_tready  (m_tready),
        .grant_id  (grant_id),
        .busy      (busy),
        .frame_cnt (frame_cnt),
        .trunc_cnt (trunc_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    beat_t src_q[NS][$];
    beat_t exp_q[NS][$];
    logic [DW-1:0] log_d[$];
    logic          log_l[$];
    int            gnt_log[$];

    logic [NS-1:0] hs;
    bit  in_frame;
    bit  draining;
    int  ds;
    int  mg;
    int  mf[NS];
    int  mt[NS];

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    function automatic int model_pick(input int last);
        int r;
        r = last;
        for (int k = NS; k >= 1; k--) begin
            if (exp_q[(last + k) % NS].size() > 0) r = (last + k) % NS;
        end
        return r;
    endfunction

    // Source frame goes to the driver; what the port must emit follows the truncation rule.
    task automatic send_frame(input int src, input int base, input int len);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            b.d = DW'(base + k);
            b.l = (k == len - 1);
            b.t = 1'b0;
            src_q[src].push_back(b);
            if (k < MB) begin
                b.l = (k == len - 1) || (k == MB - 1);
                b.t = (len > MB) && (k == MB - 1);
                exp_q[src].push_back(b);
            end
        end
    endtask

    // Model and compare, once per cycle on the falling edge.
    always @(negedge clk) begin
        beat_t e;
        if (!reset_n) begin
            for (int i = 0; i < NS; i++) begin
                exp_q[i].delete();
                mf[i] = 0;
                mt[i] = 0;
            end
            in_frame = 1'b0;
            draining = 1'b0;
            mg       = NS - 1;
            hs       = '0;
        end else begin
            for (int i = 0; i < NS; i++) begin
                chk("frame_cnt", frame_cnt[i*CW +: CW], mf[i]);
                chk("trunc_cnt", trunc_cnt[i*CW +: CW], mt[i]);
            end
            if (draining) begin
                chk("drain_m_tvalid", m_tvalid, 0);
                chk("drain_s_tready", s_tready[ds], 1);
                if (s_tvalid[ds] && s_tlast[ds]) draining = 1'b0;
            end else if (in_frame) begin
                for (int i = 0; i < NS; i++)
                    chk("s_tready_route", s_tready[i], (i == mg) ? m_tready : 1'b0);
            end
            if (m_tvalid && m_tready) begin
                if (!in_frame) begin
                    mg       = model_pick(mg);
                    in_frame = 1'b1;
                    gnt_log.push_back(int'(grant_id));
                end
                chk("beat_expected", exp_q[mg].size() > 0, 1);
                if (exp_q[mg].size() > 0) begin
                    e = exp_q[mg].pop_front();
                    chk("m_tdata", m_tdata, e.d);
                    chk("m_tlast", m_tlast, e.l);
                    chk("grant_id", grant_id, mg);
                    if (e.l) begin
                        in_frame = 1'b0;
                        mf[mg]++;
                        if (e.t) begin
                            mt[mg]++;
                            draining = 1'b1;
                            ds       = mg;
                        end
                    end
                end
                log_d.push_back(m_tdata);
                log_l.push_back(m_tlast);
            end
            for (int i = 0; i < NS; i++) hs[i] = s_tvalid[i] & s_tready[i];
        end
    end

    // Source drivers: retire handshaken beat at the edge, present next head just after.
    initial begin
        s_tvalid = '0;
        s_tlast  = '0;
        s_tdata  = '0;
        forever begin
            @(posedge clk);
            for (int i = 0; i < NS; i++)
                if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
            #1;
            for (int i = 0; i < NS; i++) begin
                if (src_q[i].size() > 0) begin
                    s_tvalid[i]          = 1'b1;
                    s_tlast[i]           = src_q[i][0].l;
                    s_tdata[i*DW +: DW]  = src_q[i][0].d;
                end else begin
                    s_tvalid[i]          = 1'b0;
                    s_tlast[i]           = 1'b0;
                    s_tdata[i*DW +: DW]  = '0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle(input string nm, input int budget);
        int n;
        n = 0;
        while ((src_q[0].size() > 0 || src_q[1].size() > 0 || busy) && n < budget) begin
            tick();
            n++;
        end
        chk({nm, "_idle_in_time"}, n < budget, 1);
    endtask

    task automatic check_seg(input string nm, input int off, input int base, input int n);
        for (int k = 0; k < n; k++) begin
            if (off + k < log_d.size()) begin
                chk({nm, "_data"}, log_d[off + k], base + k);
                chk({nm, "_last"}, log_l[off + k], k == n - 1);
            end else begin
                chk({nm, "_missing_beat"}, off + k, log_d.size());
            end
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        for (int i = 0; i < NS; i++) src_q[i].delete();
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    int pat[4] = '{1, 0, 0, 1};

    initial begin
        int n;
        reset_n  = 1'b0;
        m_tready = 1'b0;
        tick(); tick(); tick();
        chk("rst_m_tvalid", m_tvalid, 0);
        chk("rst_m_tlast", m_tlast, 0);
        chk("rst_m_tdata", m_tdata, 0);
        chk("rst_s_tready", s_tready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grant_id", grant_id, NS - 1);
        chk("rst_frame_cnt", frame_cnt, 0);
        reset_n = 1'b1;
        tick();

        // Single source, 4 beats.
        m_tready = 1'b1;
        log_d.delete(); log_l.delete();
        send_frame(0, 'h11, 4);
        tick();
        chk("t1_s_tvalid_up", s_tvalid[0], 1);
        chk("t1_latency_m_tvalid_low", m_tvalid, 0);
        tick();
        chk("t1_m_tvalid_up", m_tvalid, 1);
        chk("t1_first_data", m_tdata, 'h11);
        wait_idle("t1", 100);
        chk("t1_beats", log_d.size(), 4);
        check_seg("t1", 0, 'h11, 4);
        chk("t1_frame0", frame_cnt[CW-1:0], 1);
        chk("t1_trunc", trunc_cnt, 0);

        // Contention: two frames from src0, one from src1.
        do_reset();
        log_d.delete(); log_l.delete(); gnt_log.delete();
        send_frame(0, 'h20, 3);
        send_frame(1, 'h30, 3);
        send_frame(0, 'h40, 3);
        wait_idle("t2", 200);
        chk("t2_beats", log_d.size(), 9);
        check_seg("t2a", 0, 'h20, 3);
        check_seg("t2b", 3, 'h30, 3);
        check_seg("t2c", 6, 'h40, 3);
        chk("t2_grants", gnt_log.size(), 3);
        if (gnt_log.size() == 3) begin
            chk("t2_grant0", gnt_log[0], 0);
            chk("t2_grant1", gnt_log[1], 1);
            chk("t2_grant2", gnt_log[2], 0);
        end

        // Backpressure pattern 1,0,0,1 repeating.
        log_d.delete(); log_l.delete();
        send_frame(0, 'hA0, 5);
        n = 0;
        while ((src_q[0].size() > 0 || busy) && n < 200) begin
            m_tready = pat[n % 4][0];
            tick();
            n++;
        end
        chk("t3_idle_in_time", n < 200, 1);
        m_tready = 1'b1;
        chk("t3_beats", log_d.size(), 5);
        check_seg("t3", 0, 'hA0, 5);
        chk("t3_frame0", frame_cnt[CW-1:0], 3);

        // Truncation of a 12-beat frame at 8.
        log_d.delete(); log_l.delete();
        send_frame(1, 'hB0, 12);
        wait_idle("t4", 200);
        chk("t4_beats", log_d.size(), 8);
        check_seg("t4", 0, 'hB0, 8);
        chk("t4_trunc1", trunc_cnt[2*CW-1:CW], 1);
        chk("t4_frame1", frame_cnt[2*CW-1:CW], 2);
        chk("t4_busy", busy, 0);

        // Exactly MAX_BEATS with a real tlast.
        log_d.delete(); log_l.delete();
        send_frame(0, 'hC0, 8);
        wait_idle("t5", 200);
        chk("t5_beats", log_d.size(), 8);
        check_seg("t5", 0, 'hC0, 8);
        chk("t5_trunc0", trunc_cnt[CW-1:0], 0);
        chk("t5_frame0", frame_cnt[CW-1:0], 4);

        // Reset in the middle of a frame.
        log_d.delete(); log_l.delete();
        send_frame(0, 'hD0, 6);
        n = 0;
        while (log_d.size() < 2 && n < 50) begin
            tick();
            n++;
        end
        chk("t6_reached_beat2", n < 50, 1);
        reset_n = 1'b0;
        src_q[0].delete();
        tick();
        chk("t6_m_tvalid", m_tvalid, 0);
        chk("t6_s_tready", s_tready, 0);
        chk("t6_frame_cnt", frame_cnt, 0);
        chk("t6_trunc_cnt", trunc_cnt, 0);
        chk("t6_grant_id", grant_id, NS - 1);
        chk("t6_busy", busy, 0);
        reset_n = 1'b1;
        tick();
        log_d.delete(); log_l.delete();
        send_frame(0, 'hE0, 3);
        wait_idle("t6", 100);
        chk("t6_beats", log_d.size(), 3);
        check_seg("t6", 0, 'hE0, 3);
        chk("t6_frame0", frame_cnt[CW-1:0], 1);

        tick(); tick();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passed, total);
        $fatal(1);
    end

endmodule
